// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds the FSM state encoding and the FIFO count width helper.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int          ADDR_W_DEF   = 16;
    localparam int          DATA_W_DEF   = 16;
    localparam int          DEPTH_DEF    = 2;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, opcode} with sync flush.
// The head entry is a register read, so it is stable while not popped.
module instr_fetch_unit_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int W     = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: req/ack program-memory master feeding a
// prefetch FIFO that hands opcodes to the controller via valid/ready.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                DEPTH    = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] opcode,
    output logic [ADDR_W-1:0] op_pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target
);

    localparam int CW = cnt_w(DEPTH);
    localparam int W  = ADDR_W + DATA_W;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     count;
    logic [W-1:0]      head;
    logic              push;
    logic              pop;

    // A redirect wins over both the pending push and the pop.
    assign push     = (state == REQ) && mem_ack && !jump;
    assign pop      = op_valid && op_ready && !jump;
    assign op_valid = (count != '0);
    assign op_pc    = head[W-1:DATA_W];
    assign opcode   = head[DATA_W-1:0];

    instr_fetch_unit_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (jump),
        .push  (push),
        .din   ({mem_addr, mem_rdata}),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: begin
                    if (jump) begin
                        fetch_pc <= jump_target;
                    end else if (count < CW'(DEPTH)) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        fetch_pc <= jump ? jump_target
                                         : fetch_pc + ADDR_W'(1);
                    end else if (jump) begin
                        state    <= DRAIN;
                        fetch_pc <= jump_target;
                    end
                end
                DRAIN: begin
                    if (jump) begin
                        fetch_pc <= jump_target;
                    end
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder,
// stream-level reference model and directed scenarios.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] opcode;
    logic [15:0] op_pc;
    logic        jump;
    logic [15:0] jump_target;

    int n_chk  = 0;
    int n_fail = 0;

    bit mem_en   = 1'b1;
    bit late_ack = 1'b0;
    int lat      = 1;

    instr_fetch_unit #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .opcode      (opcode),
        .op_pc       (op_pc),
        .jump        (jump),
        .jump_target (jump_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program memory contents: word at address a is 3*a + 0x21.
    function automatic logic [15:0] memfn(input logic [15:0] a);
        return 16'(a * 16'd3 + 16'h0021);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Memory responder: acks lat cycles after mem_req is seen.
    initial begin
        int wc;
        wc        = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            if (late_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hDEAD;
            end else if (rst && mem_req) begin
                if (mem_en && wc >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = memfn(mem_addr);
                    wc        = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Stream model: expected head pc, next fetch address, occupancy.
    logic [15:0] exp_pc;
    logic [15:0] fetch_exp;
    int          cnt;
    bit          stale;
    bit          p_jump;
    bit          p_req;
    bit          p_ack;
    logic [15:0] p_addr;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
            chk("rst_op_valid", 32'(op_valid), 32'd0);
            chk("rst_opcode", 32'(opcode), 32'h0000);
            chk("rst_op_pc", 32'(op_pc), 32'h0000);
            exp_pc    = 16'h0000;
            fetch_exp = 16'h0000;
            cnt       = 0;
            stale     = 1'b0;
            p_jump    = 1'b0;
            p_req     = 1'b0;
            p_ack     = 1'b0;
            p_addr    = '0;
        end else begin
            if (p_jump) begin
                chk("flush_valid", 32'(op_valid), 32'd0);
            end
            chk("occupancy", 32'(op_valid), 32'(cnt != 0));
            if (op_valid) begin
                chk("op_pc", 32'(op_pc), 32'(exp_pc));
                chk("opcode", 32'(opcode), 32'(memfn(exp_pc)));
            end
            if (p_req && !p_ack) begin
                chk("req_hold", 32'(mem_req), 32'd1);
                chk("addr_hold", 32'(mem_addr), 32'(p_addr));
            end
            if (mem_req && !p_req) begin
                chk("req_addr", 32'(mem_addr), 32'(fetch_exp));
                chk("req_gate", 32'(cnt < DEPTH), 32'd1);
            end
            if (jump) begin
                cnt       = 0;
                exp_pc    = jump_target;
                fetch_exp = jump_target;
                if (mem_req && !mem_ack) stale = 1'b1;
                else if (mem_req && mem_ack) stale = 1'b0;
            end else begin
                if (mem_req && mem_ack) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        cnt++;
                        fetch_exp = mem_addr + 16'd1;
                    end
                end
                if (op_valid && op_ready) begin
                    cnt--;
                    exp_pc = exp_pc + 16'd1;
                end
            end
            p_jump = jump;
            p_req  = mem_req;
            p_ack  = mem_ack;
            p_addr = mem_addr;
        end
    end

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!op_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!op_valid) timeout(name);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!mem_req && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) timeout(name);
    endtask

    task automatic do_jump(input logic [15:0] t);
        drive();
        jump        = 1'b1;
        jump_target = t;
        drive();
        jump = 1'b0;
    endtask

    initial begin
        int n;
        rst         = 1'b0;
        op_ready    = 1'b0;
        jump        = 1'b0;
        jump_target = '0;
        repeat (3) drive();

        // 1: first fetch after reset
        rst = 1'b1;
        @(negedge clk);
        wait_req("t1_req");
        chk("t1_addr", 32'(mem_addr), 32'h0000);
        n = 0;
        while (!mem_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mem_ack) timeout("t1_ack");
        @(negedge clk);
        chk("t1_valid", 32'(op_valid), 32'd1);
        chk("t1_opcode", 32'(opcode), 32'h0021);
        chk("t1_op_pc", 32'(op_pc), 32'h0000);

        // 2: stalled consumer fills FIFO, then drains in order
        repeat (12) @(negedge clk);
        chk("t2_req_idle", 32'(mem_req), 32'd0);
        chk("t2_valid", 32'(op_valid), 32'd1);
        drive();
        mem_en   = 1'b0;
        op_ready = 1'b1;
        @(negedge clk);
        chk("t2_pc0", 32'(op_pc), 32'h0000);
        @(negedge clk);
        chk("t2_pc1", 32'(op_pc), 32'h0001);
        chk("t2_op1", 32'(opcode), 32'h0024);

        // 3: jump during an outstanding request
        repeat (3) @(negedge clk);
        chk("t3_req", 32'(mem_req), 32'd1);
        chk("t3_addr", 32'(mem_addr), 32'h0002);
        do_jump(16'h0100);
        repeat (2) @(negedge clk);
        chk("t3_drain_req", 32'(mem_req), 32'd1);
        chk("t3_drain_addr", 32'(mem_addr), 32'h0002);
        drive();
        mem_en = 1'b1;
        n = 0;
        while (!(mem_req && mem_addr != 16'h0002) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t3_new_addr", 32'(mem_addr), 32'h0100);
        wait_valid("t3_valid");
        chk("t3_op_pc", 32'(op_pc), 32'h0100);
        chk("t3_opcode", 32'(opcode), 32'h0321);

        // 4: jump with full FIFO and ready in the same cycle
        drive();
        op_ready = 1'b0;
        repeat (12) @(negedge clk);
        chk("t4_full_req", 32'(mem_req), 32'd0);
        chk("t4_full_valid", 32'(op_valid), 32'd1);
        drive();
        op_ready    = 1'b1;
        jump        = 1'b1;
        jump_target = 16'h0200;
        drive();
        jump     = 1'b0;
        op_ready = 1'b0;
        @(negedge clk);
        chk("t4_flushed", 32'(op_valid), 32'd0);
        wait_valid("t4_valid");
        chk("t4_op_pc", 32'(op_pc), 32'h0200);

        // 5: address wrap
        drive();
        op_ready = 1'b1;
        do_jump(16'hFFFF);
        @(negedge clk);
        wait_valid("t5_valid0");
        chk("t5_pc0", 32'(op_pc), 32'hFFFF);
        chk("t5_op0", 32'(opcode), 32'h001E);
        @(negedge clk);
        wait_valid("t5_valid1");
        chk("t5_pc1", 32'(op_pc), 32'h0000);
        chk("t5_op1", 32'(opcode), 32'h0021);

        // 6: reset mid-request, late ack ignored
        drive();
        mem_en   = 1'b0;
        op_ready = 1'b0;
        @(negedge clk);
        wait_req("t6_req");
        drive();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_req", 32'(mem_req), 32'd0);
        chk("t6_rst_valid", 32'(op_valid), 32'd0);
        drive();
        rst      = 1'b1;
        late_ack = 1'b1;
        drive();
        late_ack = 1'b0;
        mem_en   = 1'b1;
        @(negedge clk);
        wait_req("t6_req2");
        chk("t6_addr", 32'(mem_addr), 32'h0000);
        wait_valid("t6_valid");
        chk("t6_op_pc", 32'(op_pc), 32'h0000);
        chk("t6_opcode", 32'(opcode), 32'h0021);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
